subterranean_round_engine: RTL and testbench
============================================

# subterranean_round_engine

Sequential, parametrised Subterranean permutation engine built around the combinational `subterranean_round` function. It holds the 257-bit state and accepts commands over a valid/ready handshake: clear, load, single duplex round with 33-bit injection, and N blank rounds. It executes `RPC` rounds per clock through an unrolled chain and presents the state plus the 32-bit extraction word. It sits between the AEAD mode controller and the round datapath, replacing per-round state handling in the controller.

## Interface
- `RPC`, 1: rounds per clock (unroll factor); legal values 1, 2, 4, 8.
- `CNT_W`, 5: width of the round-count field; maximum blank rounds per command is 2^CNT_W−1.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: engine idle and able to accept; high in IDLE only.
- `cmd_op` input 2: 00 clear, 01 duplex, 10 blank, 11 load.
- `cmd_din` input 33: duplex input, already padded by the caller; used only by op 01.
- `cmd_rounds` input CNT_W: round count; used only by op 10.
- `load_state` input 257: new state; used only by op 11.
- `busy` output 1: high while a command executes.
- `done` output 1: one-cycle pulse when the command has completed.
- `state_o` output 257: current state register.
- `extract_o` output 32: z_j = s[12^(4j) mod 257] XOR s[(257 − 12^(4j)) mod 257], for j = 0..31, computed combinationally from `state_o`.

## Operation
- The round function R(s) is applied in this order:
  - chi: s_i ^= ~s_{i+1} & s_{i+2}
  - iota: s_0 ^= 1
  - theta: s_i ^= s_{i+3} ^ s_{i+8}
  - pi: s_i = s_{12i mod 257}
  - All indices are taken mod 257.
- Duplex injection after R: for j = 0..32, s[12^(4j) mod 257] ^= cmd_din[j].
- Blank rounds use an all-zero `cmd_din`.
- Datapath: a chain of RPC round instances. Tap k (k = 1..RPC) is the output after k rounds. The state register takes tap `min(RPC, remaining)`.
- FSM states IDLE, RUN, DONE:
  - IDLE, on the `cmd_valid & cmd_ready` handshake:
    - op 00: state <= 0, go to DONE.
    - op 11: state <= load_state, go to DONE.
    - op 01: state <= R(state) plus injection of cmd_din, go to DONE.
    - op 10 with cmd_rounds = 0: state unchanged, go to DONE.
    - op 10 with cmd_rounds > 0: remaining <= cmd_rounds, go to RUN.
  - RUN: each cycle the state advances by `min(RPC, remaining)` blank rounds and remaining decrements by the same amount. When remaining reaches 0, go to DONE.
  - DONE: `done` = 1 for this one cycle, then return to IDLE.
- Counter arithmetic: `remaining` is CNT_W bits wide and never underflows, because the subtraction is clamped by the min().
- Inputs are sampled only at handshake. Changes to `cmd_*` or `load_state` while busy are ignored.
- `cmd_valid` while not ready: the command is not accepted, and the caller holds it.
- Reset mid-operation: state, counter and FSM clear immediately. No `done` is issued for the aborted command.

## Timing
- Reset values:
  - state_o = 0
  - extract_o = 0
  - cmd_ready = 1
  - busy = 0
  - done = 0
  - FSM in IDLE
- `busy` = 1 in RUN and DONE, and 0 in IDLE. `cmd_ready` = ~busy.
- Latency from the handshake edge to `done`:
  - Ops 00, 11, 01, and op 10 with N = 0: `done` is asserted in the cycle after the handshake.
  - Op 10 with N > 0: RUN lasts ceil(N/RPC) cycles, then 1 DONE cycle.
- `state_o` holds its final value from the `done` cycle onward.
- Back-to-back commands: the next command is accepted in the cycle after `done`, so there are at least 2 cycles per command.
- Critical path: RPC rounds plus the tap mux. RPC = 8 is intended for slow clocks only.

## Test plan
- Reset and clear: assert `rst` asynchronously mid-cycle.
  - All outputs must go to 0, with `cmd_ready` = 1.
  - Then op 00: `done` must assert 1 cycle after the handshake, with state_o = 0.
- Single duplex from the zero state, RPC = 1, `cmd_din` = 33'h1 (empty padded block):
  - state_o must equal the golden vector from `subterranean_permutation.dat`.
  - extract_o must match the C model.
  - `done` must assert 1 cycle after the handshake.
- Blank rounds, RPC = 4, from a random loaded state, N = 8 then N = 7:
  - For N = 8: RUN lasts 2 cycles and the state equals 8 applications of R.
  - For N = 7: RUN lasts 2 cycles (4 + 3 rounds) and the state equals 7 applications of R.
- N = 0, and `cmd_valid` held high while busy:
  - For N = 0: state unchanged and `done` asserted after 1 cycle.
  - The second command must be accepted only once `cmd_ready` returns high.
- Reset during RUN with N = 31, RPC = 1: assert `rst` at cycle 10.
  - The state must clear and no `done` pulse may occur.
  - A new load must then behave normally.
- Cross-check across RPC ∈ {1, 2, 8}: drive the same 100-command random sequence (load, duplex, blank with N ≤ 31).
  - state_o must be identical across all three configurations after every `done`.
  - Cycle counts must match the latency formula.

Source files
------------

// File: rtl/subterranean_round_engine.sv
// Subterranean permutation engine: holds the 257-bit state and executes clear,
// load, single duplex round, and N blank rounds over a valid/ready command port.
// RPC rounds are unrolled per clock; the state register takes the tap after
// min(RPC, remaining) rounds.
//
// Handshake: a command is taken on the rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. All cmd_* and
// load_state inputs are sampled on that edge only. A caller seeing cmd_ready low
// keeps cmd_valid and its payload stable until the command is taken.
module subterranean_round_engine #(
    parameter int RPC   = 1,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [32:0]      cmd_din,
    input  logic [CNT_W-1:0] cmd_rounds,
    input  logic [256:0]     load_state,
    output logic             busy,
    output logic             done,
    output logic [256:0]     state_o,
    output logic [31:0]      extract_o,
    output logic [1:0]       fsm_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [256:0]     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [256:0]     chain;
    logic [256:0]     r1;
    logic [256:0]     sel;
    int               step;
    logic             hs;

    // Cyclic rotation: result bit i is s[(i + k) mod 257].
    function automatic logic [256:0] rotr(input logic [256:0] s, input int k);
        return (s >> k) | (s << (257 - k));
    endfunction

    // One round R: chi, iota, theta, pi.
    function automatic logic [256:0] round_f(input logic [256:0] s);
        logic [256:0] c;
        logic [256:0] t;
        logic [256:0] r;
        logic [8:0]   idx;
        c    = s ^ (~rotr(s, 1) & rotr(s, 2));
        c[0] = ~c[0];
        t    = c ^ rotr(c, 3) ^ rotr(c, 8);
        r    = '0;
        for (int i = 0; i < 257; i++) begin
            idx  = 9'((12 * i) % 257);
            r[i] = t[idx];
        end
        return r;
    endfunction

    // Duplex injection: bit j lands on position 12^(4j) mod 257 (176 = 12^4 mod 257).
    function automatic logic [256:0] inject_f(input logic [256:0] s, input logic [32:0] din);
        logic [256:0] r;
        int           p;
        r = s;
        p = 1;
        for (int j = 0; j < 33; j++) begin
            r[p[8:0]] = r[p[8:0]] ^ din[j];
            p = (p * 176) % 257;
        end
        return r;
    endfunction

    // Number of blank rounds to apply this cycle, clamped so remaining never underflows.
    always_comb begin
        step = 0;
        if (int'(rem_q) >= RPC) begin
            step = RPC;
        end else begin
            step = int'(rem_q);
        end
    end

    // Unrolled round chain; r1 feeds the duplex op, sel is the tap min(RPC, remaining).
    always_comb begin
        chain = state_q;
        r1    = state_q;
        sel   = state_q;
        for (int k = 1; k <= RPC; k++) begin
            chain = round_f(chain);
            if (k == 1) begin
                r1 = chain;
            end
            if (k == step) begin
                sel = chain;
            end
        end
    end

    assign hs = cmd_valid && !busy_q;

    // Next-state logic for the command FSM, state register and round counter.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rem_d   = rem_q;
        case (fsm_q)
            IDLE: begin
                if (hs) begin
                    fsm_d = DONE;
                    case (cmd_op)
                        2'b00: state_d = '0;
                        2'b01: state_d = inject_f(r1, cmd_din);
                        2'b10: begin
                            if (cmd_rounds != '0) begin
                                rem_d = cmd_rounds;
                                fsm_d = RUN;
                            end
                        end
                        default: state_d = load_state;
                    endcase
                end
            end
            RUN: begin
                state_d = sel;
                rem_d   = rem_q - step[CNT_W-1:0];
                if (rem_q == step[CNT_W-1:0]) begin
                    fsm_d = DONE;
                end
            end
            DONE: fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        busy_d = (fsm_d != IDLE);
        done_d = (fsm_d == DONE);
    end

    // Registers; reset aborts any command in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Extraction word: z_j = s[12^(4j)] ^ s[-12^(4j)], indices mod 257.
    always_comb begin
        int p;
        extract_o = '0;
        p = 1;
        for (int j = 0; j < 32; j++) begin
            extract_o[j] = state_q[p[8:0]] ^ state_q[9'((257 - p) % 257)];
            p = (p * 176) % 257;
        end
    end

    assign cmd_ready   = ~busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_o     = state_q;
    assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_subterranean_round_engine.sv
// Bench for subterranean_round_engine: four instances with RPC = 1, 2, 4, 8,
// each driven independently, compared against an index-level reference model.
module tb_subterranean_round_engine;

    localparam int ND = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid   [ND];
    logic         cmd_ready   [ND];
    logic [1:0]   cmd_op      [ND];
    logic [32:0]  cmd_din     [ND];
    logic [4:0]   cmd_rounds  [ND];
    logic [256:0] load_state  [ND];
    logic         busy        [ND];
    logic         done        [ND];
    logic [256:0] state_o     [ND];
    logic [31:0]  extract_o   [ND];
    logic [1:0]   fsm_state_o [ND];

    int n_checks = 0;
    int n_pass   = 0;

    logic [256:0] mdl [ND];
    logic [256:0] exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            subterranean_round_engine #(
                .RPC  (1 << g),
                .CNT_W(5)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .cmd_valid  (cmd_valid[g]),
                .cmd_ready  (cmd_ready[g]),
                .cmd_op     (cmd_op[g]),
                .cmd_din    (cmd_din[g]),
                .cmd_rounds (cmd_rounds[g]),
                .load_state (load_state[g]),
                .busy       (busy[g]),
                .done       (done[g]),
                .state_o    (state_o[g]),
                .extract_o  (extract_o[g]),
                .fsm_state_o(fsm_state_o[g])
            );
        end
    endgenerate

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [256:0] m_round(input logic [256:0] s);
        logic [256:0] a, b, c;
        for (int i = 0; i < 257; i++) a[i] = s[i] ^ (~s[(i + 1) % 257] & s[(i + 2) % 257]);
        a[0] = ~a[0];
        for (int i = 0; i < 257; i++) b[i] = a[i] ^ a[(i + 3) % 257] ^ a[(i + 8) % 257];
        for (int i = 0; i < 257; i++) c[i] = b[(12 * i) % 257];
        return c;
    endfunction

    function automatic int m_pos(input int j);
        int p = 1;
        for (int t = 0; t < 4 * j; t++) p = (p * 12) % 257;
        return p;
    endfunction

    function automatic logic [256:0] m_inject(input logic [256:0] s, input logic [32:0] din);
        logic [256:0] r = s;
        for (int j = 0; j < 33; j++) r[m_pos(j)] = r[m_pos(j)] ^ din[j];
        return r;
    endfunction

    function automatic logic [31:0] m_extract(input logic [256:0] s);
        logic [31:0] z;
        for (int j = 0; j < 32; j++) z[j] = s[m_pos(j)] ^ s[(257 - m_pos(j)) % 257];
        return z;
    endfunction

    function automatic logic [256:0] rand257();
        logic [287:0] w = '0;
        for (int i = 0; i < 9; i++) w = {w[255:0], 32'($urandom())};
        return w[256:0];
    endfunction

    function automatic int exp_lat(input int d, input logic [1:0] op, input logic [4:0] n);
        int rpc = 1 << d;
        if (op == 2'b10 && n != 0) return (int'(n) + rpc - 1) / rpc + 1;
        return 1;
    endfunction

    task automatic apply_model(input int d, input logic [1:0] op, input logic [32:0] din,
                               input logic [4:0] n, input logic [256:0] ld);
        case (op)
            2'b00: mdl[d] = '0;
            2'b01: mdl[d] = m_inject(m_round(mdl[d]), din);
            2'b10: for (int i = 0; i < int'(n); i++) mdl[d] = m_round(mdl[d]);
            default: mdl[d] = ld;
        endcase
        exp_q.push_back(mdl[d]);
    endtask

    // ---------------- driver ----------------
    task automatic do_cmd(input int d, input logic [1:0] op, input logic [32:0] din,
                          input logic [4:0] n, input logic [256:0] ld);
        int cyc;
        logic [256:0] e;
        @(negedge clk);
        check("ready_before", cmd_ready[d], 1'b1);
        cmd_op[d]     = op;
        cmd_din[d]    = din;
        cmd_rounds[d] = n;
        load_state[d] = ld;
        cmd_valid[d]  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[d]  = 1'b0;
        cmd_op[d]     = 2'($urandom_range(0, 3));
        cmd_din[d]    = {1'($urandom_range(0, 1)), 32'($urandom())};
        cmd_rounds[d] = 5'($urandom_range(0, 31));
        load_state[d] = rand257();
        apply_model(d, op, din, n, ld);
        cyc = 1;
        while (done[d] !== 1'b1 && cyc < 100) begin
            check("busy_run", busy[d], 1'b1);
            @(posedge clk);
            #1;
            cyc++;
        end
        e = exp_q.pop_front();
        check("latency", cyc, exp_lat(d, op, n));
        check("state", state_o[d], e);
        check("extract", extract_o[d], m_extract(e));
        check("busy_done", busy[d], 1'b1);
        @(posedge clk);
        #1;
        check("done_pulse", done[d], 1'b0);
        check("state_hold", state_o[d], e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [256:0] x;
        logic [256:0] golden;
        logic [1:0]   op;
        logic [32:0]  din;
        logic [4:0]   n;
        int           sel;
        int           cyc;
        logic         seen;

        for (int d = 0; d < ND; d++) begin
            cmd_valid[d]  = 1'b0;
            cmd_op[d]     = 2'b00;
            cmd_din[d]    = '0;
            cmd_rounds[d] = '0;
            load_state[d] = '0;
            mdl[d]        = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < ND; d++) begin
            check("rst_state", state_o[d], '0);
            check("rst_extract", extract_o[d], '0);
            check("rst_ready", cmd_ready[d], 1'b1);
            check("rst_busy", busy[d], 1'b0);
            check("rst_done", done[d], 1'b0);
        end

        // Mid-cycle asynchronous reset from a non-zero state
        for (int d = 0; d < ND; d++) do_cmd(d, 2'b11, '0, '0, rand257());
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check("async_state", state_o[d], '0);
            check("async_extract", extract_o[d], '0);
            check("async_ready", cmd_ready[d], 1'b1);
            check("async_busy", busy[d], 1'b0);
            mdl[d] = '0;
        end
        @(negedge clk);
        rst = 1'b0;

        // Clear, then one duplex of the empty padded block from zero
        do_cmd(0, 2'b00, '0, '0, '0);
        do_cmd(0, 2'b01, 33'h1, '0, '0);
        golden = '0;
        golden[0]  = 1'b1;
        golden[1]  = 1'b1;
        golden[64] = 1'b1;
        golden[85] = 1'b1;
        check("duplex_zero", state_o[0], golden);

        // RPC = 4: N = 8 and N = 7, then N = 0
        do_cmd(2, 2'b11, '0, '0, rand257());
        do_cmd(2, 2'b10, '0, 5'd8, '0);
        do_cmd(2, 2'b10, '0, 5'd7, '0);
        do_cmd(2, 2'b10, '0, 5'd0, '0);

        // cmd_valid held through busy; second command waits for ready
        @(negedge clk);
        check("held_ready0", cmd_ready[2], 1'b1);
        cmd_op[2]     = 2'b10;
        cmd_rounds[2] = 5'd5;
        cmd_valid[2]  = 1'b1;
        @(posedge clk);
        #1;
        x = rand257();
        cmd_op[2]     = 2'b11;
        load_state[2] = x;
        cmd_rounds[2] = 5'($urandom_range(1, 31));
        apply_model(2, 2'b10, '0, 5'd5, '0);
        cyc = 1;
        while (done[2] !== 1'b1 && cyc < 100) begin
            check("held_not_ready", cmd_ready[2], 1'b0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("held_lat", cyc, 3);
        check("held_state", state_o[2], exp_q.pop_front());
        @(posedge clk);
        #1;
        check("held_idle_ready", cmd_ready[2], 1'b1);
        check("held_idle_done", done[2], 1'b0);
        @(posedge clk);
        #1;
        cmd_valid[2] = 1'b0;
        check("held_second_done", done[2], 1'b1);
        check("held_second_state", state_o[2], x);
        mdl[2] = x;
        @(posedge clk);
        #1;

        // Reset during a 31-round run on RPC = 1
        @(negedge clk);
        cmd_op[0]     = 2'b10;
        cmd_rounds[0] = 5'd31;
        cmd_valid[0]  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done[0] === 1'b1) seen = 1'b1;
        end
        check("abort_busy", busy[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_state", state_o[0], '0);
        check("abort_busy_clr", busy[0], 1'b0);
        check("abort_ready", cmd_ready[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < ND; d++) mdl[d] = '0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done[0] === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        do_cmd(0, 2'b11, '0, '0, rand257());

        // Same random command stream on every RPC configuration
        x = rand257();
        for (int d = 0; d < ND; d++) do_cmd(d, 2'b11, '0, '0, x);
        for (int i = 0; i < 100; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      op = 2'b00;
            else if (sel <= 3) op = 2'b11;
            else if (sel <= 6) op = 2'b01;
            else               op = 2'b10;
            din = {1'($urandom_range(0, 1)), 32'($urandom())};
            n   = 5'($urandom_range(0, 31));
            x   = rand257();
            for (int d = 0; d < ND; d++) do_cmd(d, op, din, n, x);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
